// File: rtl/vga_cell_renderer_if.sv
// Pixel-stream bundle between the timing/grid front end and the cell renderer.
// The master drives scan position, cell class and game state; the slave returns the coloured pixel.
interface vga_cell_renderer_if #(
  parameter int X_W        = 10,
  parameter int Y_W        = 10,
  parameter int CELL_SHIFT = 4,
  parameter int FOOD_N     = 2
);
  localparam int CX = X_W - CELL_SHIFT;
  localparam int CY = Y_W - CELL_SHIFT;

  logic                 pix_valid;
  logic [X_W-1:0]       x_pos;
  logic [Y_W-1:0]       y_pos;
  logic [1:0]           snake;
  logic                 frame_start;
  logic [FOOD_N*CX-1:0] food_x;
  logic [FOOD_N*CY-1:0] food_y;
  logic [FOOD_N-1:0]    food_en;
  logic                 game_over;
  logic [11:0]          vga_data;
  logic                 vga_valid;

  modport master (
    output pix_valid, x_pos, y_pos, snake, frame_start,
           food_x, food_y, food_en, game_over,
    input  vga_data, vga_valid
  );

  modport slave (
    input  pix_valid, x_pos, y_pos, snake, frame_start,
           food_x, food_y, food_en, game_over,
    output vga_data, vga_valid
  );
endinterface

// File: rtl/vga_cell_renderer.sv
// Two-stage pixel colouriser: stage 1 registers cell class and food hit, stage 2 applies
// the play / game-over colour mode. Mode and blink state advance only on frame_start.
//
// state      | meaning
// PLAY       | normal colours, food blinks with blink_phase
// OVER_FLASH | food hidden, whole picture inverted while blink_phase=1
// OVER_HOLD  | snake drawn in COL_DEAD, food hidden, until game_over drops
module vga_cell_renderer #(
  parameter int          X_W           = 10,
  parameter int          Y_W           = 10,
  parameter int          CELL_SHIFT    = 4,
  parameter int          FOOD_N        = 2,
  parameter int          BLINK_FRAMES  = 16,
  parameter int          FLASH_TOGGLES = 6,
  parameter logic [11:0] COL_FOOD      = 12'hF00,
  parameter logic [11:0] COL_WALL      = 12'h0FF,
  parameter logic [11:0] COL_HEAD      = 12'h0F0,
  parameter logic [11:0] COL_BODY      = 12'hFF0,
  parameter logic [11:0] COL_BG        = 12'h000,
  parameter logic [11:0] COL_DEAD      = 12'hF00
) (
  input logic               clk,
  input logic               rst,
  vga_cell_renderer_if.slave vid_io
);
  localparam int CX   = X_W - CELL_SHIFT;
  localparam int CY   = Y_W - CELL_SHIFT;
  localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int FC_W = $clog2(FLASH_TOGGLES + 1);
  localparam logic [BC_W-1:0] BLINK_LAST = BC_W'(BLINK_FRAMES - 1);
  localparam logic [FC_W-1:0] FLASH_LAST = FC_W'(FLASH_TOGGLES);

  typedef enum logic [1:0] {PLAY, OVER_FLASH, OVER_HOLD} mode_e;

  mode_e            state_q;
  logic [BC_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  logic             blink_wrap;
  logic [FC_W-1:0]  flash_cnt_q, flash_cnt_d;

  logic             v1_q;
  logic [1:0]       cls1_q;
  logic             hit1_q, hit1_d;
  logic [11:0]      data_q, data_d;
  logic             valid_q;

  logic [CX-1:0]    cell_x;
  logic [CY-1:0]    cell_y;
  logic [11:0]      base_col, norm_col;
  logic             food_vis;

  assign cell_x = vid_io.x_pos[X_W-1:CELL_SHIFT];
  assign cell_y = vid_io.y_pos[Y_W-1:CELL_SHIFT];

  always_comb begin
    hit1_d = 1'b0;
    for (int i = 0; i < FOOD_N; i++) begin
      if (vid_io.food_en[i] &&
          cell_x == vid_io.food_x[i*CX +: CX] &&
          cell_y == vid_io.food_y[i*CY +: CY])
        hit1_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      cls1_q <= 2'b00;
      hit1_q <= 1'b0;
    end else begin
      v1_q   <= vid_io.pix_valid;
      cls1_q <= vid_io.snake;
      hit1_q <= hit1_d;
    end
  end

  always_comb begin
    blink_wrap    = (blink_cnt_q == BLINK_LAST);
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q ^ blink_wrap;
    flash_cnt_d   = flash_cnt_q + 1'b1;
  end

  // Leaving an OVER state wins over any counting on the same frame_start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= PLAY;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      flash_cnt_q   <= '0;
    end else if (vid_io.frame_start) begin
      case (state_q)
        PLAY: begin
          if (vid_io.game_over) begin
            state_q       <= OVER_FLASH;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            flash_cnt_q   <= '0;
          end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
          end
        end
        OVER_FLASH: begin
          if (!vid_io.game_over) begin
            state_q       <= PLAY;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            flash_cnt_q   <= '0;
          end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            if (blink_wrap) begin
              flash_cnt_q <= flash_cnt_d;
              if (flash_cnt_d == FLASH_LAST) state_q <= OVER_HOLD;
            end
          end
        end
        OVER_HOLD: begin
          if (!vid_io.game_over) begin
            state_q       <= PLAY;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            flash_cnt_q   <= '0;
          end
        end
        default: state_q <= PLAY;
      endcase
    end
  end

  always_comb begin
    food_vis = (state_q == PLAY) && !blink_phase_q;
    case (cls1_q)
      2'b00:   base_col = COL_BG;
      2'b01:   base_col = COL_HEAD;
      2'b10:   base_col = COL_BODY;
      default: base_col = COL_WALL;
    endcase
    norm_col = (food_vis && hit1_q) ? COL_FOOD : base_col;
    data_d   = norm_col;
    if (state_q == OVER_FLASH && blink_phase_q) data_d = ~norm_col;
    if (state_q == OVER_HOLD)
      data_d = (cls1_q == 2'b01 || cls1_q == 2'b10) ? COL_DEAD : base_col;
    if (!v1_q) data_d = 12'h000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= 12'h000;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= v1_q;
    end
  end

  assign vid_io.vga_data  = data_q;
  assign vid_io.vga_valid = valid_q;
endmodule

// File: tb/tb_vga_cell_renderer.sv
// Directed bench for vga_cell_renderer: expected pixels are queued when driven and
// compared two cycles later; blink, game-over modes and async reset are walked through.
module tb_vga_cell_renderer;
  localparam int X_W = 10, Y_W = 10, CELL_SHIFT = 4, FOOD_N = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  typedef struct {
    int          due;
    logic [11:0] data;
    logic        valid;
    string       tag;
  } exp_t;

  exp_t sb[$];

  vga_cell_renderer_if #(.X_W(X_W), .Y_W(Y_W), .CELL_SHIFT(CELL_SHIFT), .FOOD_N(FOOD_N)) vif ();

  vga_cell_renderer #(
    .X_W(X_W), .Y_W(Y_W), .CELL_SHIFT(CELL_SHIFT), .FOOD_N(FOOD_N),
    .BLINK_FRAMES(2), .FLASH_TOGGLES(2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .vid_io (vif)
  );

  always #5 clk = ~clk;

  task automatic step(input string tag, input logic v, input logic [9:0] x, input logic [9:0] y,
                      input logic [1:0] s, input logic fs, input logic [11:0] exp_data);
    exp_t e;
    vif.pix_valid   = v;
    vif.x_pos       = x;
    vif.y_pos       = y;
    vif.snake       = s;
    vif.frame_start = fs;
    sb.push_back('{due: cyc + 2, data: exp_data, valid: v, tag: tag});
    @(posedge clk);
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      tests++;
      assert (vif.vga_data === e.data) else begin
        fails++;
        $error("FAIL %s: vga_data=%h expected %h", e.tag, vif.vga_data, e.data);
      end
      tests++;
      assert (vif.vga_valid === e.valid) else begin
        fails++;
        $error("FAIL %s: vga_valid=%b expected %b", e.tag, vif.vga_valid, e.valid);
      end
    end
  endtask

  task automatic px(input string tag, input logic [9:0] x, input logic [9:0] y,
                    input logic [1:0] s, input logic [11:0] exp_data);
    step(tag, 1'b1, x, y, s, 1'b0, exp_data);
  endtask

  task automatic idle();
    step("idle", 1'b0, 10'd0, 10'd0, 2'b00, 1'b0, 12'h000);
  endtask

  task automatic frame();
    idle();
    idle();
    step("frame_start", 1'b0, 10'd0, 10'd0, 2'b00, 1'b1, 12'h000);
    idle();
  endtask

  task automatic check_zero(input string tag);
    tests++;
    assert (vif.vga_data === 12'h000) else begin
      fails++;
      $error("FAIL %s: vga_data=%h expected 000", tag, vif.vga_data);
    end
    tests++;
    assert (vif.vga_valid === 1'b0) else begin
      fails++;
      $error("FAIL %s: vga_valid=%b expected 0", tag, vif.vga_valid);
    end
  endtask

  initial begin
    vif.pix_valid   = 1'b0;
    vif.x_pos       = '0;
    vif.y_pos       = '0;
    vif.snake       = 2'b00;
    vif.frame_start = 1'b0;
    vif.food_x      = {6'd3, 6'd20};
    vif.food_y      = {6'd5, 6'd20};
    vif.food_en     = 2'b10;
    vif.game_over   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // plain classes away from food
    px("head", 10'd16, 10'd16, 2'b01, 12'h0F0);
    px("body", 10'd32, 10'd16, 2'b10, 12'hFF0);
    px("wall", 10'd48, 10'd16, 2'b11, 12'h0FF);
    idle();
    px("bg", 10'd0, 10'd0, 2'b00, 12'h000);

    // food item 1 at cell (3,5)
    px("food_wall", 10'd56, 10'd88, 2'b11, 12'hF00);
    vif.food_en = 2'b00;
    px("food_disabled", 10'd56, 10'd88, 2'b11, 12'h0FF);
    vif.food_en = 2'b01;
    px("food0_bg", 10'd320, 10'd320, 2'b00, 12'hF00);
    px("food1_disabled", 10'd56, 10'd88, 2'b11, 12'h0FF);
    vif.food_en = 2'b11;
    vif.food_x  = {6'd3, 6'd3};
    vif.food_y  = {6'd5, 6'd5};
    px("food_overlap", 10'd56, 10'd88, 2'b10, 12'hF00);
    vif.food_x  = {6'd3, 6'd20};
    vif.food_y  = {6'd5, 6'd20};
    vif.food_en = 2'b10;
    idle();

    // blink with two frames per half-period
    frame();
    px("blink_f1", 10'd56, 10'd88, 2'b11, 12'hF00);
    frame();
    px("blink_f2_wall", 10'd56, 10'd88, 2'b11, 12'h0FF);
    px("blink_f2_bg", 10'd56, 10'd88, 2'b00, 12'h000);
    frame();
    px("blink_f3", 10'd56, 10'd88, 2'b11, 12'h0FF);
    frame();
    px("blink_f4", 10'd56, 10'd88, 2'b11, 12'hF00);

    // game_over high only between frame_start pulses is ignored
    vif.game_over = 1'b1;
    idle(); idle(); idle();
    vif.game_over = 1'b0;
    frame();
    px("go_glitch_play", 10'd56, 10'd88, 2'b11, 12'hF00);

    // game over: flash then hold
    vif.game_over = 1'b1;
    frame();
    px("flash0_bg", 10'd0, 10'd0, 2'b00, 12'h000);
    px("flash0_food_hidden", 10'd56, 10'd88, 2'b11, 12'h0FF);
    px("flash0_head", 10'd16, 10'd16, 2'b01, 12'h0F0);
    frame();
    px("flash0b_bg", 10'd0, 10'd0, 2'b00, 12'h000);
    frame();
    px("flash1_bg", 10'd0, 10'd0, 2'b00, 12'hFFF);
    px("flash1_head", 10'd16, 10'd16, 2'b01, 12'hF0F);
    px("flash1_food_wall", 10'd56, 10'd88, 2'b11, 12'hF00);
    frame();
    px("flash1b_bg", 10'd0, 10'd0, 2'b00, 12'hFFF);
    frame();
    px("hold_head", 10'd16, 10'd16, 2'b01, 12'hF00);
    px("hold_body", 10'd32, 10'd16, 2'b10, 12'hF00);
    px("hold_wall", 10'd48, 10'd16, 2'b11, 12'h0FF);
    px("hold_food_wall", 10'd56, 10'd88, 2'b11, 12'h0FF);
    px("hold_food_bg", 10'd56, 10'd88, 2'b00, 12'h000);
    frame();
    px("hold_stays", 10'd16, 10'd16, 2'b01, 12'hF00);

    // game_over cleared at frame_start returns to play
    vif.game_over = 1'b0;
    frame();
    px("replay_head", 10'd16, 10'd16, 2'b01, 12'h0F0);
    px("replay_food", 10'd56, 10'd88, 2'b11, 12'hF00);
    px("replay_bg", 10'd0, 10'd0, 2'b00, 12'h000);

    // async reset in the middle of a pixel stream, while in OVER_FLASH
    vif.game_over = 1'b1;
    frame();
    px("pre_rst_head", 10'd16, 10'd16, 2'b01, 12'h0F0);
    px("pre_rst_head", 10'd16, 10'd16, 2'b01, 12'h0F0);
    vif.pix_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    sb.delete();
    @(posedge clk);
    #1;
    cyc++;
    check_zero("reset_held");
    rst = 1'b0;
    vif.game_over = 1'b0;
    px("post_rst_food", 10'd56, 10'd88, 2'b11, 12'hF00);
    idle(); idle(); idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
